// File: rtl/universal_register.sv
// WIDTH-bit register: load, shift/rotate with serial I/O, up/down count, carry and zero flags; 1-cycle latency.
// No backpressure (we is a plain clock enable); define UNIVERSAL_REGISTER_SAT_EN to saturate inc/dec.
module universal_register #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] datain,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] dataout,
    output logic             carry,
    output logic             zero,
    output logic             sout_l,
    output logic             sout_r
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_INC  = 3'b110,
        OP_DEC  = 3'b111
    } op_e;

    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             all_ones, all_zero;

    assign all_ones = &data_q;
    assign all_zero = (data_q == '0);

    always_comb begin
        data_d  = data_q;
        carry_d = carry_q;
        if (clr) begin
            data_d  = RESET_VAL;
            carry_d = 1'b0;
        end else if (we) begin
            case (op_e'(mode))
                OP_HOLD: ;
                OP_LOAD: begin
                    data_d  = datain;
                    carry_d = 1'b0;
                end
                OP_SHL: begin
                    data_d  = {data_q[WIDTH-2:0], sin_r};
                    carry_d = data_q[WIDTH-1];
                end
                OP_SHR: begin
                    data_d  = {sin_l, data_q[WIDTH-1:1]};
                    carry_d = data_q[0];
                end
                OP_ROL: begin
                    data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    carry_d = data_q[WIDTH-1];
                end
                OP_ROR: begin
                    data_d  = {data_q[0], data_q[WIDTH-1:1]};
                    carry_d = data_q[0];
                end
                // carry flags the wrap (or the clamp when saturating)
                OP_INC: begin
                    carry_d = all_ones;
`ifdef UNIVERSAL_REGISTER_SAT_EN
                    data_d  = all_ones ? data_q : data_q + WIDTH'(1);
`else
                    data_d  = data_q + WIDTH'(1);
`endif
                end
                OP_DEC: begin
                    carry_d = all_zero;
`ifdef UNIVERSAL_REGISTER_SAT_EN
                    data_d  = all_zero ? data_q : data_q - WIDTH'(1);
`else
                    data_d  = data_q - WIDTH'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= RESET_VAL;
            carry_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign dataout = data_q;
    assign carry   = carry_q;
    assign zero    = all_zero;
    assign sout_l  = data_q[WIDTH-1];
    assign sout_r  = data_q[0];

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register (WIDTH=4, RESET_VAL=4'hA); honours UNIVERSAL_REGISTER_SAT_EN.
module tb_universal_register;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic       clr;
    logic [2:0] mode;
    logic [3:0] datain;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] dataout;
    logic       carry;
    logic       zero;
    logic       sout_l;
    logic       sout_r;

    universal_register #(.WIDTH(4), .RESET_VAL(4'hA)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .clr     (clr),
        .mode    (mode),
        .datain  (datain),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .dataout (dataout),
        .carry   (carry),
        .zero    (zero),
        .sout_l  (sout_l),
        .sout_r  (sout_r)
    );

    typedef struct {
        logic [3:0] d;
        logic       c;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   md;
    int   mc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] d, input logic c);
        chk({tag, "/dataout"}, dataout, d);
        chk({tag, "/carry"},   carry,   c);
        chk({tag, "/zero"},    zero,    (d == 4'h0));
        chk({tag, "/sout_l"},  sout_l,  d[3]);
        chk({tag, "/sout_r"},  sout_r,  d[0]);
    endtask

    // drive one cycle's inputs, queue the expectation, compare after the edge
    task automatic step(input string tag, input logic c_clr, input logic c_we, input logic [2:0] c_mode,
                        input logic [3:0] c_din, input logic c_sl, input logic c_sr,
                        input logic [3:0] ed, input logic ec);
        exp_t e;
        clr    = c_clr;
        we     = c_we;
        mode   = c_mode;
        datain = c_din;
        sin_l  = c_sl;
        sin_r  = c_sr;
        e.d = ed; e.c = ec; e.tag = tag;
        exp_q.push_back(e);
        md = int'(ed);
        mc = int'(ec);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "/queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_outputs(e.tag, e.d, e.c);
        end
    endtask

    function automatic void model(input int d, input int c, input logic c_clr, input logic c_we,
                                  input logic [2:0] c_mode, input logic [3:0] c_din,
                                  input logic c_sl, input logic c_sr, output int nd, output int nc);
        nd = d;
        nc = c;
        if (c_clr) begin
            nd = 10; nc = 0;
        end else if (c_we) begin
            case (c_mode)
                3'd1: begin nd = int'(c_din); nc = 0; end
                3'd2: begin nd = ((d * 2) + int'(c_sr)) % 16; nc = d / 8; end
                3'd3: begin nd = (d / 2) + (c_sl ? 8 : 0); nc = d % 2; end
                3'd4: begin nd = ((d * 2) % 16) + (d / 8); nc = d / 8; end
                3'd5: begin nd = (d / 2) + ((d % 2) * 8); nc = d % 2; end
                3'd6: begin
                    nc = (d == 15) ? 1 : 0;
`ifdef UNIVERSAL_REGISTER_SAT_EN
                    nd = (d == 15) ? 15 : d + 1;
`else
                    nd = (d + 1) % 16;
`endif
                end
                3'd7: begin
                    nc = (d == 0) ? 1 : 0;
`ifdef UNIVERSAL_REGISTER_SAT_EN
                    nd = (d == 0) ? 0 : d - 1;
`else
                    nd = (d + 15) % 16;
`endif
                end
                default: ;
            endcase
        end
    endfunction

    initial begin
        int       nd;
        int       nc;
        logic     r_clr, r_we, r_sl, r_sr;
        logic [2:0] r_mode;
        logic [3:0] r_din;

        rst_n = 1'b1; we = 1'b0; clr = 1'b0; mode = 3'd0; datain = 4'h0; sin_l = 1'b0; sin_r = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_outputs("async_reset", 4'hA, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_outputs("reset_release", 4'hA, 1'b0);

        step("load5",     0, 1, 3'b001, 4'h5, 0, 0, 4'h5, 0);
        step("we_off",    0, 0, 3'b001, 4'hF, 0, 0, 4'h5, 0);
        step("load9",     0, 1, 3'b001, 4'h9, 0, 0, 4'h9, 0);
        step("shl",       0, 1, 3'b010, 4'h0, 1, 0, 4'h2, 1);
        step("ror",       0, 1, 3'b101, 4'h0, 1, 1, 4'h1, 0);
        step("shr",       0, 1, 3'b011, 4'h0, 1, 0, 4'h8, 1);
        step("loadE",     0, 1, 3'b001, 4'hE, 0, 0, 4'hE, 0);
        step("incF",      0, 1, 3'b110, 4'h0, 1, 1, 4'hF, 0);
        step("inc_wrap",  0, 1, 3'b110, 4'h0, 1, 1, 4'h0, 1);
        step("inc1",      0, 1, 3'b110, 4'h0, 0, 0, 4'h1, 0);
        step("dec0",      0, 1, 3'b111, 4'h0, 0, 0, 4'h0, 0);
        step("dec_wrap",  0, 1, 3'b111, 4'h0, 0, 0, 4'hF, 1);
        step("hold_mode", 0, 1, 3'b000, 4'h3, 1, 1, 4'hF, 1);
`ifdef UNIVERSAL_REGISTER_SAT_EN
        step("inc_sat",   0, 1, 3'b110, 4'h0, 0, 0, 4'hF, 1);
        step("load0",     0, 1, 3'b001, 4'h0, 0, 0, 4'h0, 0);
        step("dec_sat",   0, 1, 3'b111, 4'h0, 0, 0, 4'h0, 1);
`else
        step("inc_top",   0, 1, 3'b110, 4'h0, 0, 0, 4'h0, 1);
        step("load0",     0, 1, 3'b001, 4'h0, 0, 0, 4'h0, 0);
        step("dec_bot",   0, 1, 3'b111, 4'h0, 0, 0, 4'hF, 1);
`endif
        step("load9b",    0, 1, 3'b001, 4'h9, 0, 0, 4'h9, 0);
        step("rol",       0, 1, 3'b100, 4'h0, 0, 0, 4'h3, 1);
        step("clr_prio",  1, 1, 3'b001, 4'h3, 0, 0, 4'hA, 0);
        step("incB",      0, 1, 3'b110, 4'h0, 0, 0, 4'hB, 0);
        step("incC",      0, 1, 3'b110, 4'h0, 0, 0, 4'hC, 0);
        #2 rst_n = 1'b0;
        #1 check_outputs("midop_reset", 4'hA, 1'b0);
        md = 10; mc = 0;
        #2 rst_n = 1'b1;
        step("resume",    0, 1, 3'b110, 4'h0, 0, 0, 4'hB, 0);

        for (int i = 0; i < 60; i++) begin
            r_clr  = ($urandom_range(0, 9) == 0);
            r_we   = ($urandom_range(0, 4) != 0);
            r_mode = 3'($urandom_range(0, 7));
            r_din  = 4'($urandom_range(0, 15));
            r_sl   = 1'($urandom_range(0, 1));
            r_sr   = 1'($urandom_range(0, 1));
            model(md, mc, r_clr, r_we, r_mode, r_din, r_sl, r_sr, nd, nc);
            step("rand", r_clr, r_we, r_mode, r_din, r_sl, r_sr, 4'(nd), 1'(nc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
Parametrised successor to the team's fixed 4-bit clock-enabled register bank.
- Generalises to WIDTH bits with a programmable reset value.
- Adds per-cycle operating modes: load, shift, rotate, increment, decrement.
- Adds serial in/out, a carry/borrow flag, a synchronous clear and a zero flag.
- Used as a general datapath register, shift register or up/down counter in the xc7 examples.

Parameters:
WIDTH, 4, register width in bits (>=2)
RESET_VAL, 0, value loaded into dataout on rst_n assertion and on clr

Ports:
clk  in  1  the single clock; all state updates on its rising edge
rst_n  in  1  reset, asynchronous, active-low
we  in  1  clock enable; gates every mode operation (not clr)
clr  in  1  synchronous clear
mode  in  3  operation select (see Behaviour)
datain  in  WIDTH  parallel load data
sin_l  in  1  serial input into MSB on shift right
sin_r  in  1  serial input into LSB on shift left
dataout  out  WIDTH  register contents
carry  out  1  registered carry/borrow/shifted-out bit
zero  out  1  combinational: dataout == 0
sout_l  out  1  dataout[WIDTH-1], combinational
sout_r  out  1  dataout[0], combinational

Behaviour:
Reset
- rst_n low → immediately (async) dataout=RESET_VAL, carry=0.
- Release is synchronous to the next clk edge.
- Reset mid-operation discards any in-progress operation; no partial update.

Priority each rising edge: clr > we.
- clr=1 → dataout=RESET_VAL, carry=0, regardless of we/mode.
- clr=0, we=0 → dataout and carry hold.
- clr=0, we=1 → mode decides:
  - 000 hold: dataout and carry unchanged.
  - 001 load: dataout=datain; carry=0.
  - 010 shift left: dataout={dataout[WIDTH-2:0],sin_r}; carry=old dataout[WIDTH-1].
  - 011 shift right: dataout={sin_l,dataout[WIDTH-1:1]}; carry=old dataout[0].
  - 100 rotate left: dataout={dataout[WIDTH-2:0],dataout[WIDTH-1]}; carry=old dataout[WIDTH-1].
  - 101 rotate right: dataout={dataout[0],dataout[WIDTH-1:1]}; carry=old dataout[0].
  - 110 increment: dataout=dataout+1 mod 2^WIDTH; carry=1 only if old dataout was all-ones (wrap to 0), else 0.
  - 111 decrement: dataout=dataout-1 mod 2^WIDTH; carry=1 only if old dataout was 0 (wrap to all-ones), else 0.

Timing and width rules
- Latency: one clk from inputs to dataout/carry.
- zero, sout_l and sout_r follow dataout combinationally.
- Arithmetic is unsigned, exactly WIDTH bits; no X propagation from unused inputs (sin_l/sin_r ignored outside shift modes).
- RESET_VAL is truncated to WIDTH bits.

Optional Feature:
UNIVERSAL_REGISTER_SAT_EN
- Defined: increment at all-ones keeps dataout all-ones, carry=1; decrement at 0 keeps dataout 0, carry=1. All other modes unchanged.
- Undefined: wrap-around behaviour as specified in Behaviour.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'hA; assert rst_n=0 between clk edges → dataout=4'hA, carry=0 immediately, before any edge.
- Load/enable: we=1, mode=001, datain=4'h5 → dataout=4'h5 next cycle. Then we=0, mode=001, datain=4'hF → dataout stays 4'h5.
- Shift/rotate: dataout=4'b1001.
  - mode=010, sin_r=0 → 4'b0010, carry=1.
  - Then mode=101 → 4'b0001, carry=0.
  - Then mode=011, sin_l=1 → 4'b1000, carry=1.
- Counter wrap: dataout=4'hE, mode=110 for 3 cycles → 4'hF (c=0), 4'h0 (c=1, zero=1), 4'h1 (c=0). Then mode=111 ×2 → 4'h0 (c=0), 4'hF (c=1).
- Saturation: UNIVERSAL_REGISTER_SAT_EN defined, dataout=4'hF, mode=110 → 4'hF, carry=1. From 4'h0, mode=111 → 4'h0, carry=1.
- Priority/reset mid-op: clr=1 with we=1, mode=001, datain=4'h3 → dataout=RESET_VAL, carry=0. During an increment sequence pulse rst_n=0 → dataout=RESET_VAL asynchronously; counting resumes from RESET_VAL.
